aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Parametrised, word-serial AES key schedule supporting AES-128/192/256 via `NK`. It accepts a cipher key with a start pulse and streams the full set of `NR+1` 128-bit round keys, one every 4 cycles, each tagged with its round index. It sits between key load and the round datapath, which consumes keys as they are emitted. There is no backpressure.

## Interface
- `NK`, default 4: key length in 32-bit words. Legal values are 4, 6 and 8; any other value is an elaboration error.
- `NR`, derived as `NK+6`: number of rounds. It is a localparam, not overridable.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `key_i`, in, `32*NK`: cipher key. Word 0 is `key_i[32*NK-1 -: 32]`, and the first byte is the MSB. Sampled only on an accepted start.
- `start_i`, in, 1: start request. Accepted only when `ready_o`=1.
- `ready_o`, out, 1: idle; a start will be accepted.
- `rk_valid_o`, out, 1: one-cycle pulse; `rk_o` and `rk_idx_o` are valid.
- `rk_o`, out, 128: round key. `rk_o[127:96]` is word `4k`, `rk_o[31:0]` is word `4k+3`.
- `rk_idx_o`, out, 4: round index k, 0..NR.
- `done_o`, out, 1: one-cycle pulse coincident with the final `rk_valid_o` (k=NR).

## Operation
- **FSM: IDLE -> RUN -> IDLE.**
  - IDLE: `ready_o`=1. `start_i`=1 registers `key_i`, clears the word counter `i` to 0, loads `rcon` with 0x01, and moves to RUN.
  - RUN: produces one word `w[i]` per cycle for `i` = 0..4(NR+1)-1, i.e. 44/52/60 words.
  - After the edge that produces the last word, return to IDLE.
- **Word generation:**
  - For i<NK: `w[i]` is key word i.
  - Otherwise: `w[i] = w[i-NK] ^ t`, where t is:
    - `SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}` when i mod NK == 0;
    - `SubWord(w[i-1])` when NK==8 and i mod 8 == 4;
    - `w[i-1]` otherwise.
- **History window:** an NK-deep shift register of the last NK words, shifted in every RUN cycle.
- **i mod NK:** tracked by a separate wrapping counter. No divider.
- **RotWord:** left byte rotate, {b1,b2,b3,b0}.
- **SubWord:** four instances of the team's forward AES byte S-box (combinational).
- **rcon:** after each use, `rcon <= xtime(rcon)`, i.e. `{rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00)`. Sequence: 01,02,04,08,10,20,40,80,1B,36. Uses per run: NK=4 → 10, NK=6 → 8, NK=8 → 7.
- **Output assembly:** a 4-word accumulator takes each `w[i]` in lane `i mod 4`. When `i mod 4 == 3`, the full key is registered to `rk_o`, k = i/4 to `rk_idx_o`, and `rk_valid_o` is pulsed.
- **Start while RUN:** ignored; `key_i` is not resampled.
- **Reset at any time:** aborts the run and returns to IDLE. There is no partial-output flush.
- **Reset values:** `ready_o`=1; `rk_valid_o`=0, `done_o`=0, `rk_o`=0, `rk_idx_o`=0. Internal window, counters and `rcon` are all 0.
- **Output hold:** `rk_o` and `rk_idx_o` hold their last value between pulses and after done.

## Timing
- **Start acceptance:** start is accepted on edge T (`start_i`=1, `ready_o`=1). `ready_o` goes low after T.
- **Word timing:** word `w[i]` is produced on edge T+1+i.
- **Round-key pulses:** `rk_valid_o`=1 in the cycle after edges T+4(k+1), for k=0..NR. Consecutive pulses are 4 cycles apart, with 3 idle cycles between them.
- **Completion:** `done_o` pulses with the k=NR key, in the cycle after edge T+4(NR+1). `ready_o` returns to 1 in that same cycle.
- **Back-to-back runs:** a start in that cycle is accepted. Successive runs have no gap cycles.
- **Run length:** start to last key is 44/52/60 cycles for NK=4/6/8.
- **Latency:** first key (k=0) is 4 cycles after start. It equals key words 0..3 unmodified.

## Test plan
- **AES-128** (NK=4), key `2b7e1516 28aed2a6 abf71588 09cf4f3c`:
  - k=1 → `a0fafe17 88542cb1 23a33939 2a6c7605`;
  - k=10 → `d014f9a8 c9ee2589 e13f0cc8 b6630ca6`;
  - exactly 11 `rk_valid_o` pulses; `done_o` at cycle T+44.
- **AES-192** (NK=6), key `8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b`:
  - k=0 → first four key words;
  - k=12 → `e98ba06f 448c773c 8ecc7204 01002202`;
  - 13 pulses.
- **AES-256** (NK=8), key `603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4`:
  - k=1 → `1f352c07 3b6108d7 2d9810a3 0914dff4`;
  - k=14 → `fe4890d1 e6188d0b 046df344 706c631e`;
  - 15 pulses.
- **Start while busy, key change mid-run:**
  - pulse `start_i` with a different `key_i` at cycle T+10 of an AES-128 run;
  - the sequence is unchanged and still ends with `d014f9a8…`, with only 11 pulses.
- **Reset mid-run:**
  - assert `rst_n`=0 at T+20;
  - immediately `rk_valid_o`=0, `done_o`=0, `rk_o`=0, `rk_idx_o`=0, `ready_o`=1;
  - a fresh start then reproduces the full AES-128 vector set from k=0.
- **Back-to-back:**
  - re-assert `start_i` in the `done_o` cycle with the same key;
  - the second run emits k=0 exactly 4 cycles later, with identical keys.

Source files
------------

// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - key load and round-key stream bundle for aes_key_schedule
interface aes_key_schedule_if #(
    parameter int NK = 4
);
    logic [32*NK-1:0] key_i;
    logic             start_i;
    logic             ready_o;
    logic             rk_valid_o;
    logic [127:0]     rk_o;
    logic [3:0]       rk_idx_o;
    logic             done_o;

    modport master (
        output key_i, start_i,
        input  ready_o, rk_valid_o, rk_o, rk_idx_o, done_o
    );

    modport slave (
        input  key_i, start_i,
        output ready_o, rk_valid_o, rk_o, rk_idx_o, done_o
    );
endinterface

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - word-serial AES-128/192/256 key expansion emitting one round key per 4 cycles
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the bit offset counts down from ~a.
    logic [10:0] base;
    assign base = {~a, 3'b000};
    assign s    = SBOX[base +: 8];
endmodule

module aes_key_schedule #(
    parameter int NK = 4
) (
    input logic              clk,
    input logic              rst_n,
    aes_key_schedule_if.slave bus
);
    localparam int              NR     = NK + 6;
    localparam int              NWORDS = 4 * (NR + 1);
    localparam logic [5:0]      LAST_I = 6'(NWORDS - 1);
    localparam logic [5:0]      NK_I   = 6'(NK);
    localparam logic [2:0]      NK_M1  = 3'(NK - 1);

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $error("aes_key_schedule: NK must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t       state;
    state_t       state_next;

    logic [5:0]   i;
    logic [2:0]   i_mod;
    logic [7:0]   rcon;
    logic [31:0]  win [NK];
    logic [31:0]  acc [3];

    logic [127:0] rk_q;
    logic [3:0]   rk_idx_q;
    logic         rk_valid_q;
    logic         done_q;

    logic [31:0]  prev;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  t;
    logic [31:0]  w_new;
    logic         ready;
    logic         start_ok;
    logic         last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start_i) state_next = S_RUN;
            S_RUN:   if (last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign ready    = (state == S_IDLE);
    assign start_ok = ready && bus.start_i;
    assign last     = (state == S_RUN) && (i == LAST_I);

    // win[0] is w[i-NK], win[NK-1] is w[i-1]; the key is preloaded so the
    // first NK cycles simply rotate it out unchanged.
    assign prev   = win[NK-1];
    assign sub_in = (i_mod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .a (sub_in[8*b +: 8]),
                .s (sub_out[8*b +: 8])
            );
        end
    endgenerate

    always_comb begin
        t = prev;
        if (i_mod == 3'd0) begin
            t = sub_out ^ {rcon, 24'h000000};
        end else if (NK == 8 && i_mod == 3'd4) begin
            t = sub_out;
        end
    end

    assign w_new = (i < NK_I) ? win[0] : (win[0] ^ t);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i          <= 6'd0;
            i_mod      <= 3'd0;
            rcon       <= 8'h00;
            for (int j = 0; j < NK; j++) win[j] <= 32'h0;
            for (int j = 0; j < 3; j++) acc[j] <= 32'h0;
            rk_q       <= 128'h0;
            rk_idx_q   <= 4'd0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            if (start_ok) begin
                i     <= 6'd0;
                i_mod <= 3'd0;
                rcon  <= 8'h01;
                for (int j = 0; j < NK; j++) win[j] <= bus.key_i[32*(NK-j)-1 -: 32];
            end else if (state == S_RUN) begin
                for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
                win[NK-1] <= w_new;
                i         <= i + 6'd1;
                i_mod     <= (i_mod == NK_M1) ? 3'd0 : i_mod + 3'd1;
                if (i >= NK_I && i_mod == 3'd0) begin
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
                end
                case (i[1:0])
                    2'd0: acc[0] <= w_new;
                    2'd1: acc[1] <= w_new;
                    2'd2: acc[2] <= w_new;
                    default: begin
                        rk_q       <= {acc[0], acc[1], acc[2], w_new};
                        rk_idx_q   <= i[5:2];
                        rk_valid_q <= 1'b1;
                        done_q     <= last;
                    end
                endcase
            end
        end
    end

    assign bus.ready_o    = ready;
    assign bus.rk_valid_o = rk_valid_q;
    assign bus.rk_o       = rk_q;
    assign bus.rk_idx_o   = rk_idx_q;
    assign bus.done_o     = done_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - directed FIPS-197 vector bench for aes_key_schedule at NK=4/6/8
module tb_aes_key_schedule;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_schedule_if #(.NK(4)) b4 ();
    aes_key_schedule_if #(.NK(6)) b6 ();
    aes_key_schedule_if #(.NK(8)) b8 ();

    aes_key_schedule #(.NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    aes_key_schedule #(.NK(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));
    aes_key_schedule #(.NK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

    localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] K192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] K192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] K256_3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] K256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] rk4 [16];
    logic [127:0] rk6 [16];
    logic [127:0] rk8 [16];
    int cnt4, cnt6, cnt8;
    int dcnt4, dcnt6, dcnt8;
    int dcyc4, dcyc6, dcyc8;

    always @(negedge clk) begin
        if (b4.rk_valid_o) begin rk4[b4.rk_idx_o] = b4.rk_o; cnt4++; end
        if (b4.done_o) begin dcyc4 = cyc; dcnt4++; end
        if (b6.rk_valid_o) begin rk6[b6.rk_idx_o] = b6.rk_o; cnt6++; end
        if (b6.done_o) begin dcyc6 = cyc; dcnt6++; end
        if (b8.rk_valid_o) begin rk8[b8.rk_idx_o] = b8.rk_o; cnt8++; end
        if (b8.done_o) begin dcyc8 = cyc; dcnt8++; end
    end

    task automatic clear_caps();
        for (int j = 0; j < 16; j++) begin rk4[j] = '0; rk6[j] = '0; rk8[j] = '0; end
        cnt4 = 0; cnt6 = 0; cnt8 = 0;
        dcnt4 = 0; dcnt6 = 0; dcnt8 = 0;
        dcyc4 = 0; dcyc6 = 0; dcyc8 = 0;
    endtask

    task automatic wait_done(input int which, output bit ok);
        int base;
        base = (which == 4) ? dcnt4 : (which == 6) ? dcnt6 : dcnt8;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (((which == 4) ? dcnt4 : (which == 6) ? dcnt6 : dcnt8) != base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic launch4(input logic [127:0] key, output int t);
        @(negedge clk);
        b4.key_i = key; b4.start_i = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        b4.start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (b4.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready4: got %b expected 1", b4.ready_o); end
        checks++; if (b4.rk_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid4: got %b expected 0", b4.rk_valid_o); end
        checks++; if (b4.done_o !== 1'b0) begin errors++; $display("FAIL reset_done4: got %b expected 0", b4.done_o); end
        checks++; if (b4.rk_o !== 128'h0) begin errors++; $display("FAIL reset_rk4: got %h expected 0", b4.rk_o); end
        checks++; if (b4.rk_idx_o !== 4'd0) begin errors++; $display("FAIL reset_idx4: got %0d expected 0", b4.rk_idx_o); end
        checks++; if (b6.ready_o !== 1'b1 || b8.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready68: got %b%b expected 11", b6.ready_o, b8.ready_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        int t; bit ok;
        clear_caps();
        launch4(K128, t);
        wait_done(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL aes128_timeout: got no done expected done"); end
        checks++; if (rk4[0] !== K128) begin errors++; $display("FAIL aes128_k0: got %h expected %h", rk4[0], K128); end
        checks++; if (rk4[1] !== K128_1) begin errors++; $display("FAIL aes128_k1: got %h expected %h", rk4[1], K128_1); end
        checks++; if (rk4[2] !== K128_2) begin errors++; $display("FAIL aes128_k2: got %h expected %h", rk4[2], K128_2); end
        checks++; if (rk4[10] !== K128_10) begin errors++; $display("FAIL aes128_k10: got %h expected %h", rk4[10], K128_10); end
        checks++; if (cnt4 != 11) begin errors++; $display("FAIL aes128_pulses: got %0d expected 11", cnt4); end
        checks++; if (dcyc4 - t != 44) begin errors++; $display("FAIL aes128_done_time: got %0d expected 44", dcyc4 - t); end
        checks++; if (b4.ready_o !== 1'b1) begin errors++; $display("FAIL aes128_ready_at_done: got %b expected 1", b4.ready_o); end
        repeat (3) @(negedge clk);
        checks++; if (b4.rk_o !== K128_10 || b4.rk_idx_o !== 4'd10) begin errors++; $display("FAIL aes128_hold: got %h/%0d expected %h/10", b4.rk_o, b4.rk_idx_o, K128_10); end
        checks++; if (b4.rk_valid_o !== 1'b0 || b4.done_o !== 1'b0) begin errors++; $display("FAIL aes128_idle_pulses: got %b%b expected 00", b4.rk_valid_o, b4.done_o); end
    endtask

    task automatic test_aes192();
        int t; bit ok;
        clear_caps();
        @(negedge clk);
        b6.key_i = K192; b6.start_i = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        b6.start_i = 1'b0;
        wait_done(6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL aes192_timeout: got no done expected done"); end
        checks++; if (rk6[0] !== K192_0) begin errors++; $display("FAIL aes192_k0: got %h expected %h", rk6[0], K192_0); end
        checks++; if (rk6[1] !== K192_1) begin errors++; $display("FAIL aes192_k1: got %h expected %h", rk6[1], K192_1); end
        checks++; if (rk6[12] !== K192_12) begin errors++; $display("FAIL aes192_k12: got %h expected %h", rk6[12], K192_12); end
        checks++; if (cnt6 != 13) begin errors++; $display("FAIL aes192_pulses: got %0d expected 13", cnt6); end
        checks++; if (dcyc6 - t != 52) begin errors++; $display("FAIL aes192_done_time: got %0d expected 52", dcyc6 - t); end
    endtask

    task automatic test_aes256();
        int t; bit ok;
        clear_caps();
        @(negedge clk);
        b8.key_i = K256; b8.start_i = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        b8.start_i = 1'b0;
        wait_done(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL aes256_timeout: got no done expected done"); end
        checks++; if (rk8[1] !== K256_1) begin errors++; $display("FAIL aes256_k1: got %h expected %h", rk8[1], K256_1); end
        checks++; if (rk8[2] !== K256_2) begin errors++; $display("FAIL aes256_k2: got %h expected %h", rk8[2], K256_2); end
        checks++; if (rk8[3] !== K256_3) begin errors++; $display("FAIL aes256_k3: got %h expected %h", rk8[3], K256_3); end
        checks++; if (rk8[14] !== K256_14) begin errors++; $display("FAIL aes256_k14: got %h expected %h", rk8[14], K256_14); end
        checks++; if (cnt8 != 15) begin errors++; $display("FAIL aes256_pulses: got %0d expected 15", cnt8); end
        checks++; if (dcyc8 - t != 60) begin errors++; $display("FAIL aes256_done_time: got %0d expected 60", dcyc8 - t); end
    endtask

    task automatic test_start_busy();
        int t; bit ok;
        clear_caps();
        launch4(K128, t);
        while (cyc < t + 10) @(negedge clk);
        b4.key_i = 128'hffeeddccbbaa99887766554433221100; b4.start_i = 1'b1;
        @(posedge clk); #1;
        b4.start_i = 1'b0;
        wait_done(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: got no done expected done"); end
        checks++; if (rk4[1] !== K128_1) begin errors++; $display("FAIL busy_k1: got %h expected %h", rk4[1], K128_1); end
        checks++; if (rk4[10] !== K128_10) begin errors++; $display("FAIL busy_k10: got %h expected %h", rk4[10], K128_10); end
        checks++; if (dcyc4 - t != 44) begin errors++; $display("FAIL busy_done_time: got %0d expected 44", dcyc4 - t); end
        repeat (60) @(negedge clk);
        checks++; if (cnt4 != 11) begin errors++; $display("FAIL busy_pulses: got %0d expected 11", cnt4); end
    endtask

    task automatic test_reset_midrun();
        int t; bit ok;
        clear_caps();
        launch4(K128, t);
        while (cyc < t + 20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (b4.rk_valid_o !== 1'b0 || b4.done_o !== 1'b0) begin errors++; $display("FAIL midrst_pulses: got %b%b expected 00", b4.rk_valid_o, b4.done_o); end
        checks++; if (b4.rk_o !== 128'h0) begin errors++; $display("FAIL midrst_rk: got %h expected 0", b4.rk_o); end
        checks++; if (b4.rk_idx_o !== 4'd0) begin errors++; $display("FAIL midrst_idx: got %0d expected 0", b4.rk_idx_o); end
        checks++; if (b4.ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", b4.ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_caps();
        launch4(K128, t);
        wait_done(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout: got no done expected done"); end
        checks++; if (rk4[0] !== K128) begin errors++; $display("FAIL midrst_k0: got %h expected %h", rk4[0], K128); end
        checks++; if (rk4[1] !== K128_1) begin errors++; $display("FAIL midrst_k1: got %h expected %h", rk4[1], K128_1); end
        checks++; if (rk4[10] !== K128_10) begin errors++; $display("FAIL midrst_k10: got %h expected %h", rk4[10], K128_10); end
        checks++; if (cnt4 != 11) begin errors++; $display("FAIL midrst_pulses: got %0d expected 11", cnt4); end
    endtask

    task automatic test_back_to_back();
        int t; int d; int first; bit ok;
        clear_caps();
        launch4(K128, t);
        wait_done(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout1: got no done expected done"); end
        d = cyc;
        b4.start_i = 1'b1;
        @(posedge clk); #1;
        b4.start_i = 1'b0;
        clear_caps();
        first = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (cnt4 > 0) begin first = cyc; break; end
        end
        checks++; if (first != d + 5) begin errors++; $display("FAIL b2b_k0_time: got %0d expected %0d", first, d + 5); end
        checks++; if (rk4[0] !== K128) begin errors++; $display("FAIL b2b_k0: got %h expected %h", rk4[0], K128); end
        wait_done(4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout2: got no done expected done"); end
        checks++; if (rk4[1] !== K128_1) begin errors++; $display("FAIL b2b_k1: got %h expected %h", rk4[1], K128_1); end
        checks++; if (rk4[10] !== K128_10) begin errors++; $display("FAIL b2b_k10: got %h expected %h", rk4[10], K128_10); end
        checks++; if (cnt4 != 11) begin errors++; $display("FAIL b2b_pulses: got %0d expected 11", cnt4); end
        checks++; if (dcyc4 - (d + 1) != 44) begin errors++; $display("FAIL b2b_done_time: got %0d expected 44", dcyc4 - (d + 1)); end
    endtask

    initial begin
        b4.key_i = '0; b4.start_i = 1'b0;
        b6.key_i = '0; b6.start_i = 1'b0;
        b8.key_i = '0; b8.start_i = 1'b0;
        clear_caps();
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_start_busy();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
